pong_hcounter: RTL and testbench

- Horizontal timing chain for the Pong video path.
- Models the 7493 ripple-counter pair plus the SN74107 JK stage that forms the 256H bit, together with the 7430/7474 reset decode.
- Runs synchronously on CLK_DRV and advances on detected falling edges of the pixel-clock level CLK_N, matching the negative-edge behaviour of the discrete ICs.
- Feeds the vertical counter via VCLK_EN, and the sync/blank/net/paddle logic via H, HBLANK and HSYNC.

---
 rtl/pong_timing_pkg.sv | 44 ++++
 rtl/pong_hcounter_if.sv | 33 +++
 rtl/pong_fall_edge.sv | 21 ++
 rtl/pong_hcounter.sv | 71 +++++++
 tb/tb_pong_hcounter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_timing_pkg.sv
// Shared timing constants and types for the Pong video path.
// Horizontal values drive pong_hcounter; vertical ones are for the V chain.
package pong_timing_pkg;

  localparam int H_WIDTH     = 9;
  localparam int H_TOTAL     = 455;
  localparam int HSYNC_START = 32;
  localparam int HSYNC_END   = 64;
  localparam int HBLANK_END  = 80;

  localparam int V_WIDTH     = 9;
  localparam int V_TOTAL     = 262;
  localparam int VSYNC_START = 4;
  localparam int VSYNC_END   = 8;
  localparam int VBLANK_END  = 16;

  typedef logic [H_WIDTH-1:0] hcount_t;
  typedef logic [V_WIDTH-1:0] vcount_t;

  typedef struct packed {
    hcount_t h;
    logic    hreset;
    logic    hblank;
    logic    hsync;
  } hstate_t;

  localparam hstate_t H_RST_STATE = '{
    h:      '0,
    hreset: 1'b0,
    hblank: 1'b1,
    hsync:  1'b0
  };

  // 7430 terminal decode followed by the synchronous clear.
  function automatic hcount_t h_advance(
    input hcount_t h,
    input int      total
  );
    if (h == hcount_t'(total - 1))
      return '0;
    return h + 1'b1;
  endfunction

endpackage

// File: rtl/pong_hcounter_if.sv
// Horizontal timing bundle between the H chain and its consumers.
// master = H counter side, slave = pixel clock source / video logic.
interface pong_hcounter_if;

  logic                     CLK_N;
  pong_timing_pkg::hcount_t H;
  logic                     HRESET;
  logic                     HRESET_N;
  logic                     HBLANK;
  logic                     HSYNC;
  logic                     VCLK_EN;

  modport master (
    input  CLK_N,
    output H,
    output HRESET,
    output HRESET_N,
    output HBLANK,
    output HSYNC,
    output VCLK_EN
  );

  modport slave (
    output CLK_N,
    input  H,
    input  HRESET,
    input  HRESET_N,
    input  HBLANK,
    input  HSYNC,
    input  VCLK_EN
  );

endinterface

// File: rtl/pong_fall_edge.sv
// Falling-edge strobe for a level synchronous to the system clock.
// Stands in for the negative-edge clock input of the 74xx parts.
module pong_fall_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic fall_o
);

  logic lvl_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      lvl_q <= 1'b0;
    else
      lvl_q <= lvl_i;
  end

  assign fall_o = lvl_q & ~lvl_i;

endmodule

// File: rtl/pong_hcounter.sv
// Horizontal counter: 7493 pair + SN74107 256H stage, 7430/7474 reset,
// blank SR latch and sync decode, all stepped by the CLK_N fall strobe.
module pong_hcounter
  import pong_timing_pkg::*;
#(
  parameter int H_TOTAL_P     = H_TOTAL,
  parameter int HSYNC_START_P = HSYNC_START,
  parameter int HSYNC_END_P   = HSYNC_END,
  parameter int HBLANK_END_P  = HBLANK_END
) (
  input logic             CLK_DRV,
  input logic             RESET,
  pong_hcounter_if.master hif
);

  logic    pix_en;
  logic    wrap;
  hstate_t st_q;
  hstate_t st_d;
  logic    vclk_en_q;
  logic    vclk_en_d;

  pong_fall_edge u_fall (
    .clk_i  (CLK_DRV),
    .rst_i  (RESET),
    .lvl_i  (hif.CLK_N),
    .fall_o (pix_en)
  );

  assign wrap = (st_q.h == hcount_t'(H_TOTAL_P - 1));

  always_comb begin
    st_d      = st_q;
    vclk_en_d = 1'b0;
    if (pix_en) begin
      st_d.h      = h_advance(st_q.h, H_TOTAL_P);
      st_d.hreset = wrap;
      vclk_en_d   = wrap;
      // Blank latch: set at line start, cleared at end of blank, else hold.
      unique case (1'b1)
        (st_d.h == '0):
          st_d.hblank = 1'b1;
        (st_d.h == hcount_t'(HBLANK_END_P)):
          st_d.hblank = 1'b0;
        default:
          st_d.hblank = st_q.hblank;
      endcase
      st_d.hsync = st_d.hblank
                 & (st_d.h >= hcount_t'(HSYNC_START_P))
                 & (st_d.h <  hcount_t'(HSYNC_END_P));
    end
  end

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      st_q      <= H_RST_STATE;
      vclk_en_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      vclk_en_q <= vclk_en_d;
    end
  end

  assign hif.H        = st_q.h;
  assign hif.HRESET   = st_q.hreset;
  assign hif.HRESET_N = ~st_q.hreset;
  assign hif.HBLANK   = st_q.hblank;
  assign hif.HSYNC    = st_q.hsync;
  assign hif.VCLK_EN  = vclk_en_q;

endmodule

// File: tb/tb_pong_hcounter.sv
// Bench for pong_hcounter: vector table, 7493/74107 chain model
// run in lockstep through a scoreboard queue, plus corner sequences.
module tb_pong_hcounter;

  typedef struct {
    int   h;
    logic hb;
    logic hs;
    logic hr;
    logic vc;
  } exp_t;

  typedef struct {
    int   falls;
    int   h;
    logic hb;
    logic hs;
    logic hr;
    logic vc;
  } vec_t;

  logic clk;
  logic rst;
  int   err;
  int   chk;
  exp_t q[$];
  vec_t tbl[11];

  logic [3:0] m_a;
  logic [3:0] m_b;
  logic       m_j;
  logic       m_hb;
  logic       m_hs;
  logic       m_hr;
  logic       m_vc;
  logic       m_prev;

  pong_hcounter_if hif ();

  pong_hcounter dut (
    .CLK_DRV (clk),
    .RESET   (rst),
    .hif     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_a    = '0;
    m_b    = '0;
    m_j    = 1'b0;
    m_hb   = 1'b1;
    m_hs   = 1'b0;
    m_hr   = 1'b0;
    m_vc   = 1'b0;
    m_prev = 1'b0;
    q.delete();
  endtask

  // Two 7493 nibbles ripple into a J=K=1 SN74107 clocked by 128H falling.
  task automatic model_fall();
    int hn;
    if ({m_j, m_b, m_a} == 9'd454) begin
      m_a  = '0;
      m_b  = '0;
      m_j  = 1'b0;
      m_hr = 1'b1;
      m_vc = 1'b1;
    end else begin
      m_hr = 1'b0;
      if (m_a == 4'hF && m_b == 4'hF)
        m_j = ~m_j;
      if (m_a == 4'hF)
        m_b = m_b + 4'd1;
      m_a = m_a + 4'd1;
    end
    hn   = int'({m_j, m_b, m_a});
    m_hb = (hn < 80);
    m_hs = (hn >= 32) && (hn <= 63);
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    chk++;
    if (got != want) begin
      err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_out(input string nm, input exp_t e);
    chk++;
    if (int'(hif.H) != e.h || hif.HBLANK !== e.hb || hif.HSYNC !== e.hs ||
        hif.HRESET !== e.hr || hif.HRESET_N !== ~e.hr ||
        hif.VCLK_EN !== e.vc) begin
      err++;
      $display("FAIL %s @%0t: got H=%0d hb=%b hs=%b hr=%b hrn=%b vc=%b want H=%0d hb=%b hs=%b hr=%b hrn=%b vc=%b",
               nm, $time, hif.H, hif.HBLANK, hif.HSYNC, hif.HRESET,
               hif.HRESET_N, hif.VCLK_EN, e.h, e.hb, e.hs, e.hr, ~e.hr, e.vc);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    exp_t e;
    e = '{h: 0, hb: 1'b1, hs: 1'b0, hr: 1'b0, vc: 1'b0};
    check_out(nm, e);
  endtask

  task automatic cyc(input logic clkn);
    exp_t e;
    hif.CLK_N = clkn;
    m_vc = 1'b0;
    if (m_prev && !clkn)
      model_fall();
    m_prev = clkn;
    q.push_back('{h: int'({m_j, m_b, m_a}), hb: m_hb, hs: m_hs,
                  hr: m_hr, vc: m_vc});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_out("lockstep", e);
  endtask

  task automatic fall();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  initial begin
    int last;
    int pulses;
    int maxh;
    int guard;

    tbl[0]  = '{1,   1,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{30,  31,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1,   32,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{31,  63,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1,   64,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{15,  79,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1,   80,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{20,  100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{354, 454, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1,   0,   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1,   1,   1'b1, 1'b0, 1'b0, 1'b0};

    err = 0;
    chk = 0;
    rst = 1'b1;
    hif.CLK_N = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    rst = 1'b0;

    foreach (tbl[i]) begin
      repeat (tbl[i].falls) fall();
      check_val($sformatf("tbl%0d_h", i), int'(hif.H), tbl[i].h);
      check_val($sformatf("tbl%0d_hblank", i), int'(hif.HBLANK), int'(tbl[i].hb));
      check_val($sformatf("tbl%0d_hsync", i), int'(hif.HSYNC), int'(tbl[i].hs));
      check_val($sformatf("tbl%0d_hreset", i), int'(hif.HRESET), int'(tbl[i].hr));
      check_val($sformatf("tbl%0d_vclk", i), int'(hif.VCLK_EN), int'(tbl[i].vc));
    end

    repeat (99) fall();
    check_val("stall_pre_h", int'(hif.H), 100);
    repeat (20) cyc(1'b1);
    check_val("stall_hi_h", int'(hif.H), 100);
    cyc(1'b0);
    check_val("stall_next_h", int'(hif.H), 101);
    repeat (10) cyc(1'b0);
    check_val("stall_lo_h", int'(hif.H), 101);

    last = -1;
    pulses = 0;
    maxh = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc((i % 2) == 0);
      if (int'(hif.H) > maxh)
        maxh = int'(hif.H);
      if (hif.VCLK_EN) begin
        if (last >= 0)
          check_val("line_cycles", i - last, 910);
        last = i;
        pulses++;
      end
    end
    check_val("max_h", maxh, 454);
    check_val("vclk_pulses", pulses, 2);

    guard = 0;
    while (int'(hif.H) != 200 && guard < 500) begin
      fall();
      guard++;
    end
    check_val("pre_reset_h", int'(hif.H), 200);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    hif.CLK_N = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("held_reset");
    rst = 1'b0;
    fall();
    check_val("post_reset_h", int'(hif.H), 1);
    check_val("post_reset_hblank", int'(hif.HBLANK), 1);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
